// File: rtl/sram_arb_pkg.sv
// Shared constants and owner encoding for the two-master SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned AW_DEFAULT = 16;

    localparam int MST_M0 = 0;
    localparam int MST_M1 = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way grant logic: round-robin pointer, lock ownership and combinational grant.
//   owner    | meaning
//   OWN_NONE | no lock held, grant by pointer or fixed priority
//   OWN_M0   | M0 keeps the RAM while it requests with LOCK high
//   OWN_M1   | M1 keeps the RAM while it requests with LOCK high
module sram_rr_arb2 import sram_arb_pkg::*; #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk_sys,
    input  logic       rst_b,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    owner_t owner, owner_next;
    logic   ptr, ptr_next;   // 0: M0 has priority, 1: M1 has priority
    logic   regrant;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            owner <= OWN_NONE;
            ptr   <= 1'b0;
        end else begin
            owner <= owner_next;
            ptr   <= ptr_next;
        end
    end

    // Grants are blanked while reset is held so the RAM sees no access.
    always_comb begin
        gnt = 2'b00;
        if (!rst_b) begin
            gnt = 2'b00;
        end else if (owner == OWN_M0 && req[MST_M0]) begin
            gnt[MST_M0] = 1'b1;
        end else if (owner == OWN_M1 && req[MST_M1]) begin
            gnt[MST_M1] = 1'b1;
        end else if (FIXED_PRIO || !ptr) begin
            if (req[MST_M0])      gnt[MST_M0] = 1'b1;
            else if (req[MST_M1]) gnt[MST_M1] = 1'b1;
        end else begin
            if (req[MST_M1])      gnt[MST_M1] = 1'b1;
            else if (req[MST_M0]) gnt[MST_M0] = 1'b1;
        end
    end

    assign regrant = (owner == OWN_M0 && gnt[MST_M0]) ||
                     (owner == OWN_M1 && gnt[MST_M1]);

    always_comb begin
        ptr_next = ptr;
        if ((|gnt) && !regrant) begin
            ptr_next = gnt[MST_M0];
        end
    end

    // A master may only take the lock when the other one does not hold it.
    always_comb begin
        owner_next = owner;
        if (gnt[MST_M0] && lock[MST_M0] && owner != OWN_M1) begin
            owner_next = OWN_M0;
        end else if (gnt[MST_M1] && lock[MST_M1] && owner != OWN_M0) begin
            owner_next = OWN_M1;
        end else if (owner == OWN_M0 && !(req[MST_M0] && lock[MST_M0])) begin
            owner_next = OWN_NONE;
        end else if (owner == OWN_M1 && !(req[MST_M1] && lock[MST_M1])) begin
            owner_next = OWN_NONE;
        end
    end

endmodule

// File: rtl/sram_arbiter_2m.sv
// Two-requester arbiter in front of a single-port block RAM with registered read address.
module sram_arbiter_2m import sram_arb_pkg::*; #(
    parameter int unsigned AW         = AW_DEFAULT,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          M0_REQ,
    input  logic          M1_REQ,
    input  logic          M0_WRITE,
    input  logic          M1_WRITE,
    input  logic [AW-1:0] M0_ADDR,
    input  logic [AW-1:0] M1_ADDR,
    input  logic [31:0]   M0_WDATA,
    input  logic [31:0]   M1_WDATA,
    input  logic [3:0]    M0_BE,
    input  logic [3:0]    M1_BE,
    input  logic          M0_LOCK,
    input  logic          M1_LOCK,
    output logic          M0_GNT,
    output logic          M1_GNT,
    output logic          M0_RVALID,
    output logic          M1_RVALID,
    output logic [31:0]   M0_RDATA,
    output logic [31:0]   M1_RDATA,
    output logic [AW-1:0] SRAM_ADDR,
    output logic [31:0]   SRAM_WDATA,
    output logic [3:0]    SRAM_WREN,
    output logic          SRAM_CS,
    input  logic [31:0]   SRAM_RDATA
);

    logic [1:0] req, lock, gnt;
    owner_t     rd_owner, rd_next;

    assign req[MST_M0]  = M0_REQ;
    assign req[MST_M1]  = M1_REQ;
    assign lock[MST_M0] = M0_LOCK;
    assign lock[MST_M1] = M1_LOCK;

    sram_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk_sys (HCLK),
        .rst_b   (HRESETn),
        .req     (req),
        .lock    (lock),
        .gnt     (gnt)
    );

    assign M0_GNT = gnt[MST_M0];
    assign M1_GNT = gnt[MST_M1];

    always_comb begin
        SRAM_CS    = 1'b0;
        SRAM_ADDR  = '0;
        SRAM_WDATA = '0;
        SRAM_WREN  = 4'b0000;
        rd_next    = OWN_NONE;
        if (gnt[MST_M0]) begin
            SRAM_CS    = 1'b1;
            SRAM_ADDR  = M0_ADDR;
            SRAM_WDATA = M0_WDATA;
            SRAM_WREN  = M0_WRITE ? M0_BE : 4'b0000;
            rd_next    = M0_WRITE ? OWN_NONE : OWN_M0;
        end else if (gnt[MST_M1]) begin
            SRAM_CS    = 1'b1;
            SRAM_ADDR  = M1_ADDR;
            SRAM_WDATA = M1_WDATA;
            SRAM_WREN  = M1_WRITE ? M1_BE : 4'b0000;
            rd_next    = M1_WRITE ? OWN_NONE : OWN_M1;
        end
    end

    // Remembers which master's read the RAM is returning this cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_next;
        end
    end

    assign M0_RVALID = (rd_owner == OWN_M0);
    assign M1_RVALID = (rd_owner == OWN_M1);
    assign M0_RDATA  = M0_RVALID ? SRAM_RDATA : 32'h0;
    assign M1_RDATA  = M1_RVALID ? SRAM_RDATA : 32'h0;

endmodule

// File: doc/sram_arbiter_2m.md
Name: sram_arbiter_2m

Overview:
- Two-requester arbiter and sequencer in front of the single-port FPGA block RAM, which has registered read address and unregistered write.
- Typical requesters: the AHB-to-SRAM bridge (M0) and a debug/image loader or DMA port (M1).
- Grants at most one access per cycle and drives the RAM's ADDR/WDATA/WREN/CS.
- Returns read data one cycle after grant, steered to the owning requester with a valid strobe.

Parameters:
- AW, 16, word address width; must match the RAM instance.
- FIXED_PRIO, 0: 0 = round-robin; 1 = M0 always wins unless M1 holds a lock.

Ports:
- HCLK  in  1  single clock for arbiter and RAM.
- HRESETn  in  1  asynchronous active-low reset.
- M0_REQ, M1_REQ  in  1 each  access request; held with command stable until granted.
- M0_WRITE, M1_WRITE  in  1 each  1 = write, 0 = read.
- M0_ADDR, M1_ADDR  in  AW each  word address.
- M0_WDATA, M1_WDATA  in  32 each  write data.
- M0_BE, M1_BE  in  4 each  byte enables for writes; ignored on reads.
- M0_LOCK, M1_LOCK  in  1 each  keep ownership across consecutive granted cycles.
- M0_GNT, M1_GNT  out  1 each  combinational; command accepted this cycle.
- M0_RVALID, M1_RVALID  out  1 each  registered; read data valid.
- M0_RDATA, M1_RDATA  out  32 each  read data; zero when the matching RVALID is 0.
- SRAM_ADDR  out  AW  to RAM ADDR.
- SRAM_WDATA  out  32  to RAM WDATA.
- SRAM_WREN  out  4  to RAM WREN.
- SRAM_CS  out  1  to RAM CS.
- SRAM_RDATA  in  32  from RAM RDATA.

Behaviour:
- Reset (async assert, sync release):
  - RVALIDs = 0.
  - rr pointer = M0 highest priority.
  - lock owner = none.
  - rd_owner register = none.
  - A read granted in the cycle reset asserts is dropped; no RVALID after release.
- Grant is combinational from REQ, LOCK owner and pointer:
  - Exactly one GNT or none; GNT never asserts without its REQ.
  - Requesters must not derive REQ combinationally from GNT.
- Priority order:
  - A locked owner with REQ=1 always wins.
  - Otherwise FIXED_PRIO=1 gives M0 > M1.
  - Otherwise round-robin: the master not granted most recently has priority.
- Pointer update: on every grant, priority moves to the other master. No update while the locked owner is being re-granted.
- Lock state:
  - Lock owner is set on the edge ending a granted cycle when that master's LOCK=1.
  - It is cleared when the owner's REQ=0 or LOCK=0 in any cycle.
  - Lock cannot be taken while the other master owns it.
- SRAM drive in a granted cycle:
  - SRAM_CS = 1 and SRAM_ADDR = granted ADDR.
  - SRAM_WDATA = granted WDATA.
  - SRAM_WREN = granted BE when WRITE=1, else 4'b0000.
- SRAM drive with no grant: CS = 0, WREN = 0, ADDR and WDATA = 0.
- Read latency:
  - A read granted in cycle N gives RVALID and RDATA for that master in cycle N+1, with RDATA = SRAM_RDATA.
  - The other master's RDATA = 0.
  - Writes produce no RVALID.
- Back-to-back: one access per cycle, full throughput, no bubble between masters or between read and write.
- Write in cycle N followed by a read of the same address in N+1: the read returns the new data in N+2.
- Simultaneous REQ with no lock: grant follows the pointer; the loser waits with its command held.
- Fairness: in round-robin mode, with both requesting continuously and no locks, grants alternate M0, M1, M0, ...
- BE=0 write: CS=1, WREN=0; this is a legal no-op and is still counted as a grant.

Decomposition:
- Package sram_arb_pkg holds:
  - Master index constants MST_M0=0 and MST_M1=1.
  - Owner encoding NONE/M0/M1 (2 bits).
  - Default AW.
- One sub-module, sram_rr_arb2, holds the priority pointer, lock owner and combinational grant.
- The top level holds the command mux, rd_owner register and read-data steering.

Test Plan:
- Reset then M0 write, addr 0x0010, data 0xDEADBEEF, BE 4'hF; next cycle M0 read 0x0010 -> M0_GNT in both cycles, SRAM_WREN=4'hF in the write cycle, M0_RVALID one cycle after the read grant with M0_RDATA=0xDEADBEEF, M1_RDATA=0.
- Both REQ reads continuously, FIXED_PRIO=0, addrs 0x0001 (M0) and 0x0002 (M1) -> grants M0, M1, M0, M1; RVALID alternates one cycle behind with the matching data.
- FIXED_PRIO=1, both REQ for 4 cycles -> M0_GNT for all 4, M1_GNT=0; M1 granted the cycle after M0_REQ drops.
- M1 sets LOCK for 3 granted writes while M0 requests -> M1_GNT ×3, M0 waits; LOCK drop -> M0 granted next cycle.
- Byte-lane write of 0x000000AA with BE=4'b0001 over 0x11223344, then read -> 0x112233AA.
- HRESETn asserted in the cycle a read is granted -> all RVALID=0 and SRAM_CS=0 immediately; no RVALID after release; first post-reset contention is granted to M0.
